mic1_mem_arbiter: RTL and testbench
===================================

Name: mic1_mem_arbiter

Overview:
- Sequences all main-memory traffic for the MIC-1 core.
- Each cycle it accepts the microinstruction memory_ctrl strobes (WRITE/READ/FETCH), captures the MAR/MDR/PC operands and shares one external memory port between data (read/write) and instruction-byte fetch.
- It returns results as MDR/MBR load pulses and raises stall_o so the sequencer holds MPC/MIR while accesses are outstanding.
- It sits between the mic1 datapath and the main-memory port.

Parameters:
- ADDR_W, 32, memory byte-address width
- DATA_W, 32, memory word width (fixed 32; any other value is an elaboration error)
- TIMEOUT, 0, max cycles mem_req_o waits for mem_ack_i; 0 disables the timeout

Ports:
- clk  in  1  clock, all state on rising edge
- resetn  in  1  synchronous active-low reset
- memory_ctrl_i  in  3  microinstruction field; bit2 WRITE, bit1 READ, bit0 FETCH; sampled only when stall_o=0
- mar_i  in  32  MAR, word address
- mdr_i  in  32  MDR, write data
- pc_i  in  32  PC, byte address
- mem_req_o  out  1  memory request
- mem_we_o  out  1  1=write, 0=read
- mem_addr_o  out  ADDR_W  byte address, word aligned
- mem_wdata_o  out  32  write data
- mem_rdata_i  in  32  read data, valid with mem_ack_i
- mem_ack_i  in  1  request completion
- mdr_load_o  out  1  one-cycle pulse: load MDR from mdr_data_o
- mdr_data_o  out  32  read word
- mbr_load_o  out  1  one-cycle pulse: load MBR from mbr_data_o
- mbr_data_o  out  8  fetched byte
- stall_o  out  1  hold MPC/MIR
- err_o  out  1  sticky error flag

Behaviour:
- Reset (resetn=0 at a rising edge):
  - state=IDLE; pending flags cleared; wait counter=0.
  - mem_req_o, mem_we_o, mdr_load_o, mbr_load_o, err_o=0; mem_addr_o, mem_wdata_o, mdr_data_o, mbr_data_o=0.
  - Applies mid-access too: the request is dropped with no ack required and no load pulse.
- Capture: on an edge with stall_o=0 and memory_ctrl_i!=0:
  - data_pend is set if WRITE or READ; dkind=WRITE if bit2, else READ.
  - daddr={mar_i[29:0],2'b00}; dwdata=mdr_i.
  - fetch_pend is set if FETCH; faddr={pc_i[31:2],2'b00}; fsel=pc_i[1:0].
- WRITE and READ both set: the write is performed, the read is dropped, and err_o is set.
- FSM states IDLE, DATA, FETCH:
  - Arbitration is fixed priority: data over fetch.
  - IDLE→DATA if data_pend is captured, else →FETCH if fetch_pend is captured.
  - DATA on ack: read→mdr; then →FETCH if fetch_pend, else →IDLE.
  - FETCH on ack: →IDLE.
  - mem_req_o=1 exactly in DATA/FETCH. mem_we_o=1 only in DATA with dkind=WRITE. mem_addr_o and mem_wdata_o are stable while mem_req_o=1.
  - mem_ack_i is ignored when mem_req_o=0.
- Latency:
  - Strobe captured at edge N; mem_req_o high in cycle N+1.
  - With zero-wait ack in N+1, mdr_load_o (read) is high in cycle N+2, matching the MIC-1 rule that MDR is usable two microinstructions after READ.
  - A fetch queued behind data gets mbr_load_o one cycle after its own ack.
- Load pulses: registered, exactly one cycle.
  - mdr_data_o=mem_rdata_i sampled at ack.
  - mbr_data_o=mem_rdata_i[8*fsel +: 8] (little-endian lanes).
  - Both outputs hold their value until the next load.
- stall_o is combinational: (state!=IDLE) && !(mem_ack_i && no further pending access after this one).
  - Strobes are sampled only when stall_o=0; they are ignored, not queued, while stall_o=1.
- Timeout (TIMEOUT>0):
  - The wait counter counts cycles with mem_req_o=1 && mem_ack_i=0 and resets on each new access.
  - When it reaches TIMEOUT, the access is abandoned: no load pulse, err_o is set, and the FSM proceeds as if acked.
- err_o stays high until reset.

Decomposition:
- mic1_pkg holds:
  - enum arb_state_t {IDLE, DATA, FETCH}
  - localparams MC_FETCH=0, MC_READ=1, MC_WRITE=2 (bit indices within memory_ctrl)
  - MC_FIELD_LSB=4 (position of the field in MIR)
- Sub-module mic1_byte_sel is purely combinational: it maps a 32-bit word and a 2-bit selector to a byte.
- The FSM, counter and capture registers stay in mic1_mem_arbiter.

Test Plan:
- Read, zero-wait:
  - Stimulus: mar_i=0x10, READ strobe at edge N; memory acks in N+1 with 0xDEADBEEF.
  - Required: mem_addr_o=0x40, mem_we_o=0; mdr_load_o=1 only in N+2 with mdr_data_o=0xDEADBEEF; stall_o=0 in N+2.
- Write, 3 wait states:
  - Stimulus: mar_i=1, mdr_i=0x12345678, WRITE.
  - Required: mem_req_o=1, we=1, addr=0x4, wdata=0x12345678 held stable 4 cycles; no load pulses; stall_o high until the ack cycle.
- READ+FETCH in the same cycle:
  - Stimulus: mar_i=2, pc_i=0x103.
  - Required: data request (addr 0x8) precedes fetch request (addr 0x100). The fetch word 0xAABBCCDD gives mbr_data_o=0xAA. mdr_load_o and mbr_load_o occur in separate cycles.
- WRITE+READ strobes together:
  - Required: one write transaction only; err_o=1 and it stays 1 until resetn=0.
- Timeout:
  - Stimulus: TIMEOUT=4, FETCH issued, ack never arrives.
  - Required: mem_req_o drops after 4 cycles, no mbr_load_o, err_o=1, state back to IDLE.
- Reset mid-access:
  - Stimulus: resetn=0 during DATA with mem_req_o=1.
  - Required: next cycle mem_req_o=0, stall_o=0, no load pulse; a later stray ack is ignored.

Source files
------------

// File: rtl/mic1_pkg.sv
// Shared types and constants for the MIC-1 memory arbiter slice.
// No logic; constants and enums only.
// Not applicable (no handshakes).
package mic1_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    FETCH = 2'd2
  } arb_state_t;

  // Bit indices within the microinstruction memory_ctrl field
  localparam int MC_FETCH     = 0;
  localparam int MC_READ      = 1;
  localparam int MC_WRITE     = 2;

  // Position of the memory_ctrl field inside the MIR
  localparam int MC_FIELD_LSB = 4;

endpackage

// File: rtl/mic1_byte_sel.sv
// Picks one little-endian byte lane out of a 32-bit word.
// Latency: purely combinational.
// Backpressure: none (no handshake).
module mic1_byte_sel (
  input  logic [31:0] word,
  input  logic [1:0]  sel,
  output logic [7:0]  lane
);

  // sel=0 selects bits [7:0], sel=3 selects bits [31:24]
  assign lane = word[{sel, 3'b000} +: 8];

endmodule

// File: rtl/mic1_mem_arbiter.sv
// Shares one memory port between MIC-1 data accesses and instruction-byte fetches.
// Latency: strobe at edge N -> mem_req_o in N+1 -> load pulse the cycle after ack.
// Backpressure: stall_o holds the sequencer; strobes seen while stalled are dropped.
module mic1_mem_arbiter
  import mic1_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [2:0]        memory_ctrl_i,
  input  logic [31:0]       mar_i,
  input  logic [DATA_W-1:0] mdr_i,
  input  logic [31:0]       pc_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              mdr_load_o,
  output logic [DATA_W-1:0] mdr_data_o,
  output logic              mbr_load_o,
  output logic [7:0]        mbr_data_o,
  output logic              stall_o,
  output logic              err_o
);

  if (DATA_W != 32) begin : g_bad_data_w
    $error("mic1_mem_arbiter: DATA_W must be 32");
  end

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  arb_state_t        state, state_nxt, launch;
  logic              fetch_pend;
  logic              dkind_wr;
  logic [ADDR_W-1:0] daddr, faddr;
  logic [DATA_W-1:0] dwdata;
  logic [1:0]        fsel;
  logic [CNT_W-1:0]  wait_cnt;
  logic              cap, cap_wr, cap_rd, cap_fe;
  logic              tmo_hit, done, more_pend;
  logic [7:0]        fetch_lane;
  logic              unused_mar_hi;

  // MAR is a word address; its top two bits fall off the byte address
  assign unused_mar_hi = ^mar_i[31:30];

  assign cap_wr = memory_ctrl_i[MC_WRITE];
  assign cap_rd = memory_ctrl_i[MC_READ];
  assign cap_fe = memory_ctrl_i[MC_FETCH];

  assign mem_req_o = (state != IDLE);
  // An abandoned (timed-out) access completes exactly like an acked one
  assign tmo_hit   = (TIMEOUT > 0) && mem_req_o && !mem_ack_i &&
                     (wait_cnt == CNT_W'(TIMEOUT - 1));
  assign done      = mem_req_o && (mem_ack_i || tmo_hit);
  assign more_pend = (state == DATA) && fetch_pend;
  assign stall_o   = mem_req_o && !(done && !more_pend);
  assign cap       = !stall_o && (memory_ctrl_i != 3'b000);

  assign mem_we_o    = (state == DATA) && dkind_wr;
  assign mem_addr_o  = (state == DATA)  ? daddr :
                       (state == FETCH) ? faddr : '0;
  assign mem_wdata_o = mem_we_o ? dwdata : '0;

  mic1_byte_sel u_byte_sel (
    .word (mem_rdata_i),
    .sel  (fsel),
    .lane (fetch_lane)
  );

  // Next state: data wins over fetch; a finishing access may hand straight to a new capture
  always_comb begin
    launch    = IDLE;
    state_nxt = state;
    if (cap) begin
      launch = (cap_wr || cap_rd) ? DATA : FETCH;
    end
    case (state)
      IDLE:    state_nxt = launch;
      DATA:    if (done) state_nxt = fetch_pend ? FETCH : launch;
      FETCH:   if (done) state_nxt = launch;
      default: state_nxt = IDLE;
    endcase
  end

  // State, operand capture, wait counter, load pulses and sticky error
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      fetch_pend <= 1'b0;
      dkind_wr   <= 1'b0;
      daddr      <= '0;
      faddr      <= '0;
      dwdata     <= '0;
      fsel       <= 2'b00;
      wait_cnt   <= '0;
      mdr_load_o <= 1'b0;
      mdr_data_o <= '0;
      mbr_load_o <= 1'b0;
      mbr_data_o <= 8'h00;
      err_o      <= 1'b0;
    end else begin
      state <= state_nxt;

      if (cap) begin
        dkind_wr   <= cap_wr;
        daddr      <= ADDR_W'({mar_i[29:0], 2'b00});
        dwdata     <= mdr_i;
        faddr      <= ADDR_W'({pc_i[31:2], 2'b00});
        fsel       <= pc_i[1:0];
        fetch_pend <= cap_fe;
      end else if (state == FETCH && done) begin
        fetch_pend <= 1'b0;
      end

      // Restarts from zero for every new access
      wait_cnt <= (mem_req_o && !done) ? wait_cnt + 1'b1 : '0;

      mdr_load_o <= (state == DATA) && !dkind_wr && mem_ack_i;
      if ((state == DATA) && !dkind_wr && mem_ack_i) begin
        mdr_data_o <= mem_rdata_i;
      end

      mbr_load_o <= (state == FETCH) && mem_ack_i;
      if ((state == FETCH) && mem_ack_i) begin
        mbr_data_o <= fetch_lane;
      end

      // Simultaneous WRITE+READ keeps the write and drops the read
      if ((cap && cap_wr && cap_rd) || tmo_hit) begin
        err_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mic1_mem_arbiter.sv
// Directed bench for mic1_mem_arbiter with a transaction/load scoreboard.
// Latency: checks sampled 2 time units after each rising edge; monitor on falling edge.
// Backpressure: bench memory acks by hand, including wait states and no-ack timeouts.
module tb_mic1_mem_arbiter;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic [2:0]  memory_ctrl;
  logic [31:0] mar, mdr, pc;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mdr_load, mbr_load, stall, err;
  logic [31:0] mdr_data;
  logic [7:0]  mbr_data;

  int n_cmp = 0;
  int n_bad = 0;

  txn_t        exp_txn[$];
  logic [31:0] exp_mdr[$];
  logic [7:0]  exp_mbr[$];

  mic1_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .memory_ctrl_i (memory_ctrl),
    .mar_i         (mar),
    .mdr_i         (mdr),
    .pc_i          (pc),
    .mem_req_o     (mem_req),
    .mem_we_o      (mem_we),
    .mem_addr_o    (mem_addr),
    .mem_wdata_o   (mem_wdata),
    .mem_rdata_i   (mem_rdata),
    .mem_ack_i     (mem_ack),
    .mdr_load_o    (mdr_load),
    .mdr_data_o    (mdr_data),
    .mbr_load_o    (mbr_load),
    .mbr_data_o    (mbr_data),
    .stall_o       (stall),
    .err_o         (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every completed handshake and every load pulse must match a queued expectation
  always @(negedge clk) begin
    if (mem_req && mem_ack) begin
      chk("txn_expected", 32'(exp_txn.size() != 0), 32'd1);
      if (exp_txn.size() != 0) begin
        txn_t t;
        t = exp_txn.pop_front();
        chk("txn_addr", mem_addr, t.addr);
        chk("txn_we", 32'(mem_we), 32'(t.we));
        if (t.we) chk("txn_wdata", mem_wdata, t.wdata);
      end
    end
    if (mdr_load) begin
      chk("mdr_expected", 32'(exp_mdr.size() != 0), 32'd1);
      if (exp_mdr.size() != 0) chk("mdr_data_sb", mdr_data, exp_mdr.pop_front());
    end
    if (mbr_load) begin
      chk("mbr_expected", 32'(exp_mbr.size() != 0), 32'd1);
      if (exp_mbr.size() != 0) chk("mbr_data_sb", 32'(mbr_data), 32'(exp_mbr.pop_front()));
    end
  end

  initial begin
    resetn = 1'b0; memory_ctrl = 3'b000; mar = '0; mdr = '0; pc = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    step(); step();
    #1;
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_mdr_load", 32'(mdr_load), 0);
    chk("rst_mbr_load", 32'(mbr_load), 0);
    chk("rst_mdr_data", mdr_data, 0);
    chk("rst_mbr_data", 32'(mbr_data), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_stall", 32'(stall), 0);
    resetn = 1'b1;
    step();

    // Read, zero wait states
    mar = 32'h10; memory_ctrl = 3'b010;
    exp_txn.push_back('{32'h40, 1'b0, 32'h0});
    exp_mdr.push_back(32'hDEADBEEF);
    #1 chk("t1_idle_stall", 32'(stall), 0);
    step();
    memory_ctrl = 3'b000; mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    #1;
    chk("t1_req", 32'(mem_req), 1);
    chk("t1_we", 32'(mem_we), 0);
    chk("t1_addr", mem_addr, 32'h40);
    chk("t1_stall_ack", 32'(stall), 0);
    chk("t1_mdr_early", 32'(mdr_load), 0);
    step();
    mem_ack = 1'b0;
    #1;
    chk("t1_mdr_load", 32'(mdr_load), 1);
    chk("t1_mdr_data", mdr_data, 32'hDEADBEEF);
    chk("t1_stall_after", 32'(stall), 0);
    chk("t1_req_after", 32'(mem_req), 0);
    step();
    chk("t1_mdr_pulse_end", 32'(mdr_load), 0);

    // Write, three wait states; strobes during the stall must be ignored
    mar = 32'h1; mdr = 32'h12345678; memory_ctrl = 3'b100;
    exp_txn.push_back('{32'h4, 1'b1, 32'h12345678});
    step();
    memory_ctrl = 3'b010; mar = 32'h7; mdr = 32'h0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t2_req", 32'(mem_req), 1);
      chk("t2_we", 32'(mem_we), 1);
      chk("t2_addr", mem_addr, 32'h4);
      chk("t2_wdata", mem_wdata, 32'h12345678);
      chk("t2_stall", 32'(stall), 1);
      step();
    end
    memory_ctrl = 3'b000; mem_ack = 1'b1;
    #1;
    chk("t2_req_ack", 32'(mem_req), 1);
    chk("t2_addr_ack", mem_addr, 32'h4);
    chk("t2_wdata_ack", mem_wdata, 32'h12345678);
    chk("t2_stall_ack", 32'(stall), 0);
    step();
    mem_ack = 1'b0;
    #1;
    chk("t2_req_done", 32'(mem_req), 0);
    chk("t2_no_mdr", 32'(mdr_load), 0);
    chk("t2_no_mbr", 32'(mbr_load), 0);
    chk("t2_mdr_hold", mdr_data, 32'hDEADBEEF);

    // READ+FETCH together: data first, then the fetch
    mar = 32'h2; pc = 32'h103; memory_ctrl = 3'b011;
    exp_txn.push_back('{32'h8, 1'b0, 32'h0});
    exp_txn.push_back('{32'h100, 1'b0, 32'h0});
    exp_mdr.push_back(32'h0BADF00D);
    exp_mbr.push_back(8'hAA);
    step();
    memory_ctrl = 3'b000; mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
    #1;
    chk("t3_addr_data", mem_addr, 32'h8);
    chk("t3_stall_data", 32'(stall), 1);
    step();
    mem_rdata = 32'hAABBCCDD;
    #1;
    chk("t3_mdr_load", 32'(mdr_load), 1);
    chk("t3_addr_fetch", mem_addr, 32'h100);
    chk("t3_we_fetch", 32'(mem_we), 0);
    chk("t3_mbr_early", 32'(mbr_load), 0);
    chk("t3_stall_fetch", 32'(stall), 0);
    step();
    mem_ack = 1'b0;
    #1;
    chk("t3_mbr_load", 32'(mbr_load), 1);
    chk("t3_mbr_data", 32'(mbr_data), 32'hAA);
    chk("t3_mdr_separate", 32'(mdr_load), 0);
    step();
    chk("t3_mbr_pulse_end", 32'(mbr_load), 0);

    // WRITE+READ together: write only, sticky error
    chk("t4_err_before", 32'(err), 0);
    mar = 32'h5; mdr = 32'hCAFEF00D; memory_ctrl = 3'b110;
    exp_txn.push_back('{32'h14, 1'b1, 32'hCAFEF00D});
    step();
    memory_ctrl = 3'b000; mem_ack = 1'b1;
    #1;
    chk("t4_we", 32'(mem_we), 1);
    chk("t4_addr", mem_addr, 32'h14);
    chk("t4_stall", 32'(stall), 0);
    step();
    mem_ack = 1'b0;
    #1;
    chk("t4_err", 32'(err), 1);
    chk("t4_req_done", 32'(mem_req), 0);
    step(); step(); step();
    chk("t4_err_sticky", 32'(err), 1);
    chk("t4_no_mdr", 32'(mdr_load), 0);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    chk("t4_err_cleared", 32'(err), 0);

    // Fetch that is never acked: abandoned after 4 request cycles
    pc = 32'h20; memory_ctrl = 3'b001;
    step();
    memory_ctrl = 3'b000;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t5_req_wait", 32'(mem_req), 1);
      chk("t5_stall_wait", 32'(stall), 1);
      step();
    end
    #1 chk("t5_req_last", 32'(mem_req), 1);
    step();
    #1;
    chk("t5_req_dropped", 32'(mem_req), 0);
    chk("t5_err", 32'(err), 1);
    chk("t5_stall_idle", 32'(stall), 0);
    chk("t5_no_mbr", 32'(mbr_load), 0);
    step();
    chk("t5_no_mbr_late", 32'(mbr_load), 0);

    // Reset in the middle of a data access; later stray ack ignored
    mar = 32'h3; memory_ctrl = 3'b010;
    step();
    memory_ctrl = 3'b000;
    #1;
    chk("t6_req", 32'(mem_req), 1);
    chk("t6_addr", mem_addr, 32'hC);
    chk("t6_stall", 32'(stall), 1);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    #1;
    chk("t6_req_dropped", 32'(mem_req), 0);
    chk("t6_stall_clear", 32'(stall), 0);
    chk("t6_no_mdr", 32'(mdr_load), 0);
    chk("t6_err_clear", 32'(err), 0);
    chk("t6_mdr_data_clear", mdr_data, 0);
    mem_ack = 1'b1; mem_rdata = 32'h55;
    step();
    #1;
    chk("t6_stray_req", 32'(mem_req), 0);
    chk("t6_stray_stall", 32'(stall), 0);
    step();
    mem_ack = 1'b0;
    #1;
    chk("t6_stray_mdr", 32'(mdr_load), 0);
    chk("t6_stray_mbr", 32'(mbr_load), 0);
    step();

    chk("end_txn_left", 32'(exp_txn.size()), 0);
    chk("end_mdr_left", 32'(exp_mdr.size()), 0);
    chk("end_mbr_left", 32'(exp_mbr.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
